// File: rtl/controle_exibicao.sv
// Sequence playback controller: walks memory addresses 0..lim_r. Each item is
// loaded for one cycle, shown on leds for T_ACESO cycles, then blanked for
// T_APAGADO cycles. A one-cycle fim_exibicao pulse marks normal completion.
module controle_exibicao #(
    parameter int unsigned T_ACESO   = 1000,
    parameter int unsigned T_APAGADO = 250
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       abortar,
    input  logic [3:0] limite,
    input  logic [3:0] dado_memoria,
    output logic [3:0] endereco,
    output logic [3:0] leds,
    output logic       ocupado,
    output logic       fim_exibicao,
    output logic [4:0] db_estado
);

    typedef enum logic [2:0] {
        StEspera  = 3'd0,
        StCarrega = 3'd1,
        StAceso   = 3'd2,
        StApagado = 3'd3,
        StFim     = 3'd4
    } estado_t;

    // Terminal counts: the timer runs 0..T-1 inside each timed state.
    localparam logic [15:0] UltimoAceso   = 16'(T_ACESO - 1);
    localparam logic [15:0] UltimoApagado = 16'(T_APAGADO - 1);

    estado_t     estado;
    logic [3:0]  lim_r;
    logic [15:0] timer;

    // State, dwell timer, address, display and completion pulse, all registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado       <= StEspera;
            lim_r        <= 4'd0;
            timer        <= 16'd0;
            endereco     <= 4'd0;
            leds         <= 4'd0;
            fim_exibicao <= 1'b0;
        end else if (abortar) begin
            estado       <= StEspera;
            timer        <= 16'd0;
            endereco     <= 4'd0;
            leds         <= 4'd0;
            fim_exibicao <= 1'b0;
        end else begin
            fim_exibicao <= 1'b0;
            case (estado)
                StEspera: begin
                    timer    <= 16'd0;
                    endereco <= 4'd0;
                    leds     <= 4'd0;
                    if (iniciar) begin
                        lim_r  <= limite;
                        estado <= StCarrega;
                    end
                end
                StCarrega: begin
                    // endereco settled one cycle ago, so memory data is valid now
                    leds   <= dado_memoria;
                    timer  <= 16'd0;
                    estado <= StAceso;
                end
                StAceso: begin
                    if (timer == UltimoAceso) begin
                        timer  <= 16'd0;
                        leds   <= 4'd0;
                        estado <= StApagado;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                StApagado: begin
                    if (timer == UltimoApagado) begin
                        timer <= 16'd0;
                        if (endereco == lim_r) begin
                            fim_exibicao <= 1'b1;
                            estado       <= StFim;
                        end else begin
                            endereco <= endereco + 4'd1;
                            estado   <= StCarrega;
                        end
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                StFim: begin
                    endereco <= 4'd0;
                    leds     <= 4'd0;
                    estado   <= StEspera;
                end
                default: begin
                    timer    <= 16'd0;
                    endereco <= 4'd0;
                    leds     <= 4'd0;
                    estado   <= StEspera;
                end
            endcase
        end
    end

    // Status outputs decoded purely from the state register.
    always_comb begin
        ocupado   = (estado != StEspera);
        db_estado = {2'b00, estado};
    end

endmodule

// File: tb/tb_controle_exibicao.sv
// Directed bench for controle_exibicao with T_ACESO=3, T_APAGADO=2 (6 cycles per item).
module tb_controle_exibicao;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic       abortar;
    logic [3:0] limite;
    logic [3:0] dado_memoria;
    logic [3:0] endereco;
    logic [3:0] leds;
    logic       ocupado;
    logic       fim_exibicao;
    logic [4:0] db_estado;

    logic [3:0] mem [16];
    int checks = 0;
    int errors = 0;

    controle_exibicao #(
        .T_ACESO  (3),
        .T_APAGADO(2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .iniciar     (iniciar),
        .abortar     (abortar),
        .limite      (limite),
        .dado_memoria(dado_memoria),
        .endereco    (endereco),
        .leds        (leds),
        .ocupado     (ocupado),
        .fim_exibicao(fim_exibicao),
        .db_estado   (db_estado)
    );

    // Memory read settles within the cycle after endereco changes.
    assign dado_memoria = mem[endereco];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " estado"}, 32'(db_estado), 32'd0);
        check({tag, " leds"}, 32'(leds), 32'd0);
        check({tag, " endereco"}, 32'(endereco), 32'd0);
        check({tag, " ocupado"}, 32'(ocupado), 32'd0);
        check({tag, " fim"}, 32'(fim_exibicao), 32'd0);
    endtask

    // Expected outputs in cycle n (cycle 1 starts at the edge that sampled iniciar).
    task automatic check_cycle(input string tag, input int n, input int lim);
        int total, item, fase;
        logic [4:0] e_st;
        logic [3:0] e_leds, e_end;
        logic       e_fim;
        total = 6 * (lim + 1) + 1;
        if (n == total) begin
            e_st = 5'd4; e_leds = 4'd0; e_end = 4'(lim); e_fim = 1'b1;
        end else begin
            item  = (n - 1) / 6;
            fase  = (n - 1) % 6;
            e_end = 4'(item);
            e_fim = 1'b0;
            if (fase == 0) begin
                e_st = 5'd1; e_leds = 4'd0;
            end else if (fase <= 3) begin
                e_st = 5'd2; e_leds = mem[item];
            end else begin
                e_st = 5'd3; e_leds = 4'd0;
            end
        end
        check($sformatf("%s c%0d estado", tag, n), 32'(db_estado), 32'(e_st));
        check($sformatf("%s c%0d leds", tag, n), 32'(leds), 32'(e_leds));
        check($sformatf("%s c%0d endereco", tag, n), 32'(endereco), 32'(e_end));
        check($sformatf("%s c%0d fim", tag, n), 32'(fim_exibicao), 32'(e_fim));
        check($sformatf("%s c%0d ocupado", tag, n), 32'(ocupado), 32'd1);
    endtask

    // Pulse iniciar so that the next edge samples it; returns positioned in cycle 1.
    task automatic start(input logic [3:0] lim);
        limite  = lim;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
    endtask

    initial begin
        int peak;
        reset   = 1'b1;
        iniciar = 1'b0;
        abortar = 1'b0;
        limite  = 4'd0;
        for (int i = 0; i < 16; i++) mem[i] = 4'd0;
        #2;
        check_idle("reset");
        tick();
        reset = 1'b0;
        tick();
        check_idle("post reset");

        // Single item
        mem[0] = 4'h5;
        start(4'd0);
        check_cycle("lim0", 1, 0);
        for (int n = 2; n <= 7; n++) begin
            tick();
            check_cycle("lim0", n, 0);
        end
        tick();
        check_idle("lim0 end");

        // Three items
        mem[0] = 4'h3; mem[1] = 4'hA; mem[2] = 4'h6;
        start(4'd2);
        check_cycle("lim2", 1, 2);
        for (int n = 2; n <= 19; n++) begin
            tick();
            check_cycle("lim2", n, 2);
        end
        tick();
        check_idle("lim2 end");

        // Restart request and limite change during ACESO of item 1 are ignored
        start(4'd2);
        check_cycle("ign", 1, 2);
        for (int n = 2; n <= 19; n++) begin
            tick();
            if (n == 8) begin
                iniciar = 1'b1;
                limite  = 4'd0;
            end else begin
                iniciar = 1'b0;
            end
            check_cycle("ign", n, 2);
        end
        iniciar = 1'b0;
        tick();
        check_idle("ign end");

        // Abort during APAGADO of item 1
        start(4'd2);
        for (int n = 2; n <= 11; n++) tick();
        check_cycle("abort", 11, 2);
        abortar = 1'b1;
        tick();
        abortar = 1'b0;
        check_idle("abort next");
        for (int n = 0; n < 8; n++) begin
            tick();
            check({"abort quiet fim"}, 32'(fim_exibicao), 32'd0);
            check({"abort quiet estado"}, 32'(db_estado), 32'd0);
        end

        // abortar beats iniciar in ESPERA
        iniciar = 1'b1;
        abortar = 1'b1;
        limite  = 4'd2;
        tick();
        iniciar = 1'b0;
        abortar = 1'b0;
        check_idle("abort+iniciar");
        tick();
        check_idle("abort+iniciar after");

        // Asynchronous reset mid-period during ACESO
        start(4'd2);
        tick();
        tick();
        check_cycle("areset", 3, 2);
        #3;
        reset = 1'b1;
        #1;
        check_idle("areset async");
        #2;
        reset = 1'b0;
        tick();
        check_idle("areset after");
        for (int n = 0; n < 10; n++) begin
            tick();
            check("areset no fim", 32'(fim_exibicao), 32'd0);
        end

        // Full sixteen-item playback
        for (int i = 0; i < 16; i++) mem[i] = 4'(15 - i);
        mem[15] = 4'h9;
        peak = 0;
        start(4'd15);
        check_cycle("lim15", 1, 15);
        for (int n = 2; n <= 97; n++) begin
            tick();
            if (int'(endereco) > peak) peak = int'(endereco);
            check_cycle("lim15", n, 15);
        end
        check("lim15 peak endereco", 32'(peak), 32'd15);
        tick();
        check_idle("lim15 end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/controle_exibicao.md
CONTROLE_EXIBICAO -- requirements
Module: controle_exibicao

Interface
REQ-001 Parameter T_ACESO, default 1000, clock cycles each sequence item is shown on leds; the legal range SHALL be 1..65535.
REQ-002 Parameter T_APAGADO, default 250, clock cycles of blank gap after each item; the legal range SHALL be 1..65535.
REQ-003 clock  input  1  single system clock; all state SHALL change on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 iniciar  input  1  start request for sequence playback; sampled only in ESPERA.
REQ-006 abortar  input  1  synchronous abort; has priority over every other input except reset.
REQ-007 limite  input  4  index of the last memory address to show; latched at start.
REQ-008 dado_memoria  input  4  memory data for the current endereco, valid one cycle after endereco changes (synchronous read).
REQ-009 endereco  output  4  memory address being played back.
REQ-010 leds  output  4  item currently displayed; 0 when blank.
REQ-011 ocupado  output  1  high in every state except ESPERA.
REQ-012 fim_exibicao  output  1  one-cycle pulse when playback completes normally.
REQ-013 db_estado  output  5  current state code for the debug display.

Function
REQ-014 The FSM SHALL have states ESPERA=0, CARREGA=1, ACESO=2, APAGADO=3, FIM=4, and db_estado SHALL equal the current code.
REQ-015 ESPERA: endereco=0, leds=0; iniciar=1 SHALL latch limite into lim_r and move to CARREGA on the same edge.
REQ-016 iniciar SHALL be ignored outside ESPERA; a changing limite SHALL not affect a running playback.
REQ-017 CARREGA SHALL last exactly 1 cycle, then move to ACESO; on that edge dado_memoria SHALL be captured into the leds register.
REQ-018 ACESO SHALL last exactly T_ACESO cycles with leds holding the captured value, then move to APAGADO.
REQ-019 APAGADO SHALL last exactly T_APAGADO cycles with leds=0.
REQ-020 At the end of APAGADO, if endereco==lim_r the FSM SHALL go to FIM; otherwise endereco SHALL increment by 1 and the FSM SHALL go to CARREGA.
REQ-021 FIM SHALL last 1 cycle with fim_exibicao=1 and leds=0, then return to ESPERA with endereco cleared to 0.
REQ-022 The dwell timer SHALL be 16 bits, SHALL be cleared on entry to each timed state, and SHALL never wrap within a state.
REQ-023 Each item SHALL take exactly 1+T_ACESO+T_APAGADO cycles.
REQ-024 fim_exibicao SHALL assert (lim_r+1)*(1+T_ACESO+T_APAGADO)+1 cycles after the edge that sampled iniciar.
REQ-025 limite=0 SHALL play exactly one item.
REQ-026 limite=15 SHALL play 16 items; endereco SHALL never exceed 15 or wrap.
REQ-027 abortar=1 in any state SHALL force ESPERA on the next edge with leds=0 and endereco=0, and SHALL not pulse fim_exibicao.
REQ-028 If abortar=1 and iniciar=1 in ESPERA on the same cycle, abortar SHALL win and the FSM SHALL stay in ESPERA.
REQ-029 All outputs SHALL be registered or decoded only from registered state, with no combinational path from inputs.

Reset
REQ-030 reset=1 SHALL immediately force ESPERA, endereco=0, leds=0, ocupado=0, fim_exibicao=0, db_estado=0, timer=0, lim_r=0, independent of clock.
REQ-031 Reset asserted mid-playback SHALL discard the sequence with no fim_exibicao pulse.
REQ-032 After reset deasserts, the first iniciar SHALL start a fresh playback from address 0.

Verification (T_ACESO=3, T_APAGADO=2)
REQ-033 limite=0, memory[0]=5, iniciar pulse -> CARREGA 1 cycle, leds=5 for 3 cycles, leds=0 for 2, fim_exibicao high 7 cycles after the sampling edge, then ESPERA.
REQ-034 limite=2, memory={3,A,6} -> leds shows 3,A,6 each for 3 cycles with 2-cycle gaps, endereco goes 0,1,2, fim_exibicao at cycle 19, ocupado high cycles 1-19.
REQ-035 Second iniciar during ACESO of item 1 -> ignored; playback and fim timing are unchanged.
REQ-036 abortar during APAGADO of item 1 (limite=2) -> ESPERA next edge, leds=0, endereco=0, no fim_exibicao.
REQ-037 Async reset pulse mid-clock-period during ACESO -> outputs zero before the next edge; a following iniciar with limite=15 plays 16 items and endereco peaks at 15.
